// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Word-addressed data memory sitting on the load/store port of the MEM stage.
// It takes one request at a time through a valid/ready handshake. It inserts
// LATENCY wait states, then returns load data or commits store data. The
// response is a one-cycle resp_valid_o strobe. Misaligned or out-of-range
// accesses are flagged with resp_err_o and are not performed.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid_i   request present
//   req_write_i   1 = store, 0 = load
//   req_addr_i    byte address
//   req_wdata_i   store data
//   req_ready_o   high while IDLE; a request is accepted when valid && ready
//   resp_valid_o  one-cycle response strobe
//   resp_rdata_o  load data (0 for stores and errors), held until next response
//   resp_err_o    access rejected, held until next response
//   busy_o        a request is in flight
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int unsigned               DATA_WIDTH   = 32,
    parameter int unsigned               MEMORY_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0]     BASE_ADDR    = 32'h1001_0000,
    parameter int unsigned               LATENCY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o
);

    localparam int unsigned           IDX_W     = $clog2(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] SPAN      = DATA_WIDTH'(MEMORY_DEPTH * 4);
    localparam logic [3:0]            WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [3:0]            wait_cnt;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_write;
    logic [DATA_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [DATA_WIDTH-1:0] offset;
    logic                  acc_err;
    logic [IDX_W-1:0]      acc_idx;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    assign accept = (state == IDLE) && req_valid_i;

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state   = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        busy_o       = 1'b1;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    next_state = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign enter_resp = (next_state == RESP);

    // With LATENCY=0 the response edge is the accept edge itself, so the
    // request is taken straight from the inputs while IDLE.
    assign acc_write = (state == IDLE) ? req_write_i : lat_write;
    assign acc_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;

    // Range check on the full-width offset before truncating to an index, so
    // addresses past the array never alias onto low words.
    assign offset  = acc_addr - BASE_ADDR;
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) || (offset >= SPAN);
    assign acc_idx = offset[IDX_W+1:2];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch, wait counter and registered response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write_i;
                lat_addr  <= req_addr_i;
                lat_wdata <= req_wdata_i;
                wait_cnt  <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err_o   <= acc_err;
                resp_rdata_o <= (acc_write || acc_err) ? '0 : mem[acc_idx];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately not reset; contents survive reset. The
    // write enable is still qualified by reset so a store pending at reset is
    // dropped rather than committed.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule
